// File: rtl/clk_step_ctrl_if.sv
// Bus between the clock-enable controller and whoever drives its mode and debug controls.
// The master drives mode/div/step/halt; the slave (clk_step_ctrl) returns cpu_ce, ce_count and state.
interface clk_step_ctrl_if #(
  parameter int DIV_W = 21,
  parameter int CNT_W = 16
);
  logic [1:0]       mode;
  logic [DIV_W-1:0] div;
  logic             step_btn;
  logic             halt_req;
  logic             cpu_ce;
  logic [CNT_W-1:0] ce_count;
  logic [1:0]       state;

  modport master (
    output mode, div, step_btn, halt_req,
    input  cpu_ce, ce_count, state
  );

  modport slave (
    input  mode, div, step_btn, halt_req,
    output cpu_ce, ce_count, state
  );
endinterface

// File: rtl/clk_step_ctrl.sv
// CPU clock-enable controller: RUN / DIV / STEP / HALT modes producing a registered cpu_ce pulse.
// Optional macro STEP_DEBOUNCE_EN inserts a DEB_CYC-cycle debounce filter on the step button.
module clk_step_ctrl #(
  parameter int DIV_W   = 21,
  parameter int DEB_CYC = 16,
  parameter int CNT_W   = 16
) (
  input  logic           clk,
  input  logic           rst,
  clk_step_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_DIV  = 2'b01,
    ST_STEP = 2'b10,
    ST_HALT = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [DIV_W-1:0] div_last;
  logic             step_pend_q, step_pend_d;
  logic             ce_q, ce_d;
  logic [CNT_W-1:0] ce_count_q, ce_count_d;
  logic             state_chg;
  logic             sync1_q, sync2_q;
  logic             step_rise;

  // A DEB_CYC below 2 cannot describe a filter; this named scope makes such a build easy to spot.
  if (DEB_CYC < 2) begin : g_deb_cyc_invalid
  end

  // ---------------------------------------------------------------------------
  // Step button: two-flop synchronizer, then (optionally) the debounce filter.
  // ---------------------------------------------------------------------------
  // NOTE: reset is synchronous here, so it lives inside the clocked branch rather than the sensitivity list.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make sync2_q take the old sync1_q, giving a true two-stage chain.
      sync1_q <= bus.step_btn;
      sync2_q <= sync1_q;
    end
  end

`ifdef STEP_DEBOUNCE_EN
  localparam int DEB_W = $clog2(DEB_CYC);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);

  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             level_q, level_d;

  always_comb begin
    // NOTE: every output gets a default first so no path through this block infers a latch.
    level_d   = level_q;
    deb_cnt_d = '0;
    if (sync2_q != level_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        level_d = ~level_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      deb_cnt_q <= '0;
      level_q   <= 1'b0;
    end else begin
      deb_cnt_q <= deb_cnt_d;
      level_q   <= level_d;
    end
  end

  assign step_rise = level_d & ~level_q;
`else
  // Without the filter the accepted level is the synchronized level itself.
  assign step_rise = sync1_q & ~sync2_q;
`endif

  // ---------------------------------------------------------------------------
  // Mode FSM and enable generation
  // ---------------------------------------------------------------------------
  assign div_last  = (bus.div <= DIV_W'(1)) ? '0 : bus.div - DIV_W'(1);
  assign state_chg = (state_d != state_q);

  always_comb begin
    state_d     = state_t'(bus.mode);
    div_cnt_d   = div_cnt_q;
    step_pend_d = step_pend_q | (step_rise && (state_q == ST_STEP));
    ce_d        = 1'b0;
    ce_count_d  = ce_count_q;

    if (bus.halt_req) begin
      state_d = ST_HALT;
    end

    case (state_q)
      ST_RUN: begin
        ce_d = 1'b1;
      end
      ST_DIV: begin
        // ">=" lets a mid-count shrink of div fire on the very next compare.
        if (div_cnt_q >= div_last) begin
          ce_d      = 1'b1;
          div_cnt_d = '0;
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      ST_STEP: begin
        if (step_pend_q) begin
          ce_d        = 1'b1;
          step_pend_d = step_rise;
        end
      end
      default: begin
        ce_d = 1'b0;
      end
    endcase

    if (state_chg) begin
      div_cnt_d   = '0;
      step_pend_d = 1'b0;
    end

    if (ce_d) begin
      ce_count_d = ce_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_HALT;
      div_cnt_q   <= '0;
      step_pend_q <= 1'b0;
      ce_q        <= 1'b0;
      ce_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      step_pend_q <= step_pend_d;
      ce_q        <= ce_d;
      ce_count_q  <= ce_count_d;
    end
  end

  assign bus.cpu_ce   = ce_q;
  assign bus.ce_count = ce_count_q;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_clk_step_ctrl.sv
// Directed testbench for clk_step_ctrl: expected values are queued by the stimulus and popped at each check.
// Expectations for the step tests follow the STEP_DEBOUNCE_EN build setting.
module tb_clk_step_ctrl;

  localparam int DIV_W   = 21;
  localparam int DEB_CYC = 16;
  localparam int CNT_W   = 16;

`ifdef STEP_DEBOUNCE_EN
  localparam int STEP_LAT      = DEB_CYC + 3;
  localparam int BOUNCE_PULSES = 1;
`else
  localparam int STEP_LAT      = 3;
  localparam int BOUNCE_PULSES = 4;
`endif

  logic clk;
  logic rst;

  clk_step_ctrl_if #(.DIV_W(DIV_W), .CNT_W(CNT_W)) bus ();

  clk_step_ctrl #(
    .DIV_W  (DIV_W),
    .DEB_CYC(DEB_CYC),
    .CNT_W  (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int sb[$];
  int step_pulses;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_val(input int v);
    sb.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] observed);
    int exp_v;
    compared++;
    if (sb.size() == 0) begin
      mismatched++;
      $error("FAIL %s: observed %0d, nothing queued as expected", tag, observed);
    end else begin
      exp_v = sb.pop_front();
      assert (observed === 32'(exp_v)) else begin
        mismatched++;
        $error("FAIL %s: observed %0d expected %0d", tag, observed, exp_v);
      end
    end
  endtask

  // Counts pulses over n cycles and records the smallest and largest spacing between them.
  task automatic count_window(input int n, output int pulses, output int gmin, output int gmax);
    int last;
    last   = -1;
    pulses = 0;
    gmin   = 1 << 30;
    gmax   = 0;
    for (int i = 1; i <= n; i++) begin
      tick(1);
      if (bus.cpu_ce === 1'b1) begin
        if (last >= 0) begin
          if (i - last < gmin) gmin = i - last;
          if (i - last > gmax) gmax = i - last;
        end
        last = i;
        pulses++;
      end
    end
  endtask

  task automatic step_run(input int n);
    for (int i = 0; i < n; i++) begin
      tick(1);
      if (bus.cpu_ce === 1'b1) step_pulses++;
    end
  endtask

  initial begin
    int pulses, gmin, gmax, lat, found;

    rst          = 1'b1;
    bus.mode     = 2'b00;
    bus.div      = '0;
    bus.step_btn = 1'b0;
    bus.halt_req = 1'b0;
    tick(3);

    expect_val(3); check("reset_state", 32'(bus.state));
    expect_val(0); check("reset_ce", 32'(bus.cpu_ce));
    expect_val(0); check("reset_count", 32'(bus.ce_count));

    // RUN start-up latency
    rst = 1'b0;
    tick(1);
    expect_val(0); check("run_c1_state", 32'(bus.state));
    expect_val(0); check("run_c1_ce", 32'(bus.cpu_ce));
    tick(1);
    expect_val(1); check("run_c2_ce", 32'(bus.cpu_ce));
    expect_val(1); check("run_c2_count", 32'(bus.ce_count));
    tick(8);
    expect_val(1); check("run_c10_ce", 32'(bus.cpu_ce));
    expect_val(9); check("run_c10_count", 32'(bus.ce_count));

    // One-cycle halt request in RUN
    bus.halt_req = 1'b1;
    tick(1);
    expect_val(3); check("halt_t1_state", 32'(bus.state));
    bus.halt_req = 1'b0;
    tick(1);
    expect_val(0); check("halt_t2_ce", 32'(bus.cpu_ce));
    expect_val(0); check("halt_t2_state", 32'(bus.state));
    tick(1);
    expect_val(1); check("halt_resume_ce", 32'(bus.cpu_ce));

    // DIV mode
    bus.mode = 2'b01;
    bus.div  = DIV_W'(5);
    tick(12);
    count_window(50, pulses, gmin, gmax);
    expect_val(10); check("div5_pulses", 32'(pulses));
    expect_val(5);  check("div5_gap_min", 32'(gmin));
    expect_val(5);  check("div5_gap_max", 32'(gmax));

    bus.div = DIV_W'(4);
    tick(8);
    count_window(40, pulses, gmin, gmax);
    expect_val(10); check("div4_pulses", 32'(pulses));
    expect_val(4);  check("div4_gap_min", 32'(gmin));
    expect_val(4);  check("div4_gap_max", 32'(gmax));

    bus.div = '0;
    count_window(20, pulses, gmin, gmax);
    expect_val(20); check("div0_pulses", 32'(pulses));
    expect_val(1);  check("div0_gap_max", 32'(gmax));

    // HALT via mode
    bus.mode = 2'b11;
    tick(2);
    count_window(10, pulses, gmin, gmax);
    expect_val(0); check("halt_mode_pulses", 32'(pulses));
    expect_val(3); check("halt_mode_state", 32'(bus.state));

    // STEP: bounces followed by a long hold
    bus.mode = 2'b10;
    bus.step_btn = 1'b0;
    tick(5);
    expect_val(2); check("step_state", 32'(bus.state));
    step_pulses = 0;
    repeat (3) begin
      bus.step_btn = 1'b1;
      step_run(3);
      bus.step_btn = 1'b0;
      step_run(3);
    end
    bus.step_btn = 1'b1;
    step_run(100);
    expect_val(BOUNCE_PULSES); check("step_bounce_pulses", 32'(step_pulses));
    bus.step_btn = 1'b0;
    step_pulses = 0;
    step_run(40);
    expect_val(0); check("step_release_pulses", 32'(step_pulses));

    // STEP: clean press latency and single pulse while held
    bus.step_btn = 1'b1;
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      tick(1);
      if (bus.cpu_ce === 1'b1) begin
        lat = i;
        break;
      end
    end
    expect_val(STEP_LAT); check("step_latency", 32'(lat));
    step_pulses = 0;
    step_run(50);
    expect_val(0); check("step_hold_pulses", 32'(step_pulses));
    bus.step_btn = 1'b0;
    tick(40);

    // ce_count wrap after 65535 RUN pulses
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    bus.mode = 2'b00;
    tick(65536);
    expect_val(65535); check("wrap_preload_count", 32'(bus.ce_count));
    tick(1);
    expect_val(0); check("wrap_count", 32'(bus.ce_count));
    expect_val(1); check("wrap_ce", 32'(bus.cpu_ce));

    // Reset in the middle of a DIV count
    bus.mode = 2'b01;
    bus.div  = DIV_W'(5);
    found = 0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (bus.cpu_ce === 1'b1) begin
        found = 1;
        break;
      end
    end
    expect_val(1); check("middiv_pulse_seen", 32'(found));
    tick(3);
    expect_val(0); check("middiv_cnt3_ce", 32'(bus.cpu_ce));
    rst = 1'b1;
    tick(1);
    expect_val(0); check("middiv_rst_ce", 32'(bus.cpu_ce));
    expect_val(0); check("middiv_rst_count", 32'(bus.ce_count));
    expect_val(3); check("middiv_rst_state", 32'(bus.state));
    rst = 1'b0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/clk_step_ctrl.md
# clk_step_ctrl

Clock-enable controller for the CPU core. Runs on the single board clock and issues a one-cycle `cpu_ce` pulse that gates every architectural register update in the core. It provides full-speed, divided-rate, single-step (push-button) and halt modes for bring-up and debug. The clock itself is never gated or divided; only the enable is.

## Interface
- `DIV_W`, 21, width of the divide counter and `div` input
- `DEB_CYC`, 16, consecutive stable cycles required to accept a new step-button level (≥2)
- `CNT_W`, 16, width of `ce_count`
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `mode`  in  2  00 RUN, 01 DIV, 10 STEP, 11 HALT
- `div`  in  DIV_W  divide ratio in DIV mode; 0 and 1 both mean every cycle
- `step_btn`  in  1  raw, asynchronous step push-button, active-high
- `halt_req`  in  1  synchronous halt request from the core (e.g. HLT instruction)
- `cpu_ce`  out  1  registered clock-enable pulse to the core
- `ce_count`  out  CNT_W  number of `cpu_ce` pulses issued, wraps
- `state`  out  2  current FSM state (encoding = RUN/DIV/STEP/HALT as for `mode`)

Clock is `clk`; reset is `rst`, synchronous, active-high, sampled on rising `clk`.

## Operation
- Reset: `cpu_ce`=0, `ce_count`=0, `state`=HALT, div counter=0, synchronizer/debounce regs=0, accepted button level=0.
- FSM: `state` follows the registered `mode` each cycle, except `halt_req`=1 forces HALT while asserted. Leaving HALT requires `halt_req`=0 and `mode`≠11.
- Any `state` change clears the div counter and discards a pending step.
- RUN: `cpu_ce`=1 every cycle.
- DIV: counter counts 0..N-1, N=max(div,1); `cpu_ce`=1 in the cycle after counter==N-1, counter then returns to 0. `div` changed mid-count takes effect immediately; if counter ≥ new N-1, it fires on the next compare and wraps to 0.
- STEP: `step_btn` through 2-flop synchronizer, then debounce filter; each accepted 0→1 transition of the filtered level produces exactly one `cpu_ce` pulse. Releases and bounces produce nothing. Holding the button issues one pulse only.
- HALT: `cpu_ce`=0.
- `ce_count` increments by 1 in the cycle `cpu_ce` is 1, wraps 2^CNT_W-1 → 0.
- Debounce: counter resets whenever synchronized input equals accepted level; counts otherwise; when it reaches DEB_CYC-1 the accepted level toggles and counter resets.

## Timing
- `cpu_ce` is a flop output; no combinational path from any input.
- RUN: first `cpu_ce`=1 in the second cycle after `rst` falls with `mode`=00 (one cycle for state, one for ce).
- `halt_req` asserted in cycle t → `cpu_ce`=0 from cycle t+2; the pulse at t+1 may still issue.
- DIV with `div`=4: `cpu_ce` high exactly 1 of every 4 cycles, period 4.
- STEP latency: button edge → 2 sync cycles + DEB_CYC debounce cycles + 1 output cycle.
- `rst` mid-operation wins over everything: next cycle all outputs at reset values.

## Configuration
- `STEP_DEBOUNCE_EN` defined: debounce filter as above.
- Not defined: filter removed; accepted level = synchronized level; step latency = 2 sync cycles + 1 output cycle. All other behaviour identical.

## Test plan
- Reset then `mode`=00 for 10 cycles → `cpu_ce`=1 from cycle 2 on, `ce_count`=9 at cycle 10 (first pulse at cycle 2 after release).
- `mode`=01, `div`=5, 50 cycles → exactly 10 pulses, spaced 5 apart; `div`=0 → pulse every cycle.
- `mode`=10, button bounces 3 times (each <DEB_CYC cycles) then held 100 cycles → exactly one `cpu_ce` pulse; without `STEP_DEBOUNCE_EN` bounces yield 4 pulses.
- RUN with `halt_req` pulsed at cycle t → `state`=HALT at t+1, `cpu_ce`=0 at t+2; release with `mode`=00 → pulses resume.
- `ce_count` preloaded via 65535 RUN cycles → next pulse wraps to 0.
- `rst` asserted mid-DIV count (counter=3 of 5) → next cycle `cpu_ce`=0, `ce_count`=0, `state`=HALT.
